// File: rtl/fetch_unit.sv
// Fetch stage: PC generation, 1-cycle instruction memory port, and an
// in-order bundle queue feeding decode with redirect flush.
module fetch_unit #(
    parameter int FETCH_WIDTH   = 2,
    parameter int CPU_ADDR_BITS = 32,
    parameter int CPU_DATA_BITS = 32,
    parameter logic [CPU_ADDR_BITS-1:0] RESET_PC = '0,
    parameter int FQ_DEPTH      = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    output logic [CPU_ADDR_BITS-1:0]             icache_addr,
    output logic                                 icache_re,
    input  logic [FETCH_WIDTH*CPU_DATA_BITS-1:0] icache_dout,
    input  logic                                 icache_dout_val,
    output logic                                 icache_stall,
    input  logic                                 redirect_val,
    input  logic [CPU_ADDR_BITS-1:0]             redirect_pc,
    output logic                                 fq_valid,
    output logic [CPU_ADDR_BITS-1:0]             fq_pc,
    output logic [FETCH_WIDTH*CPU_DATA_BITS-1:0] fq_instr,
    input  logic                                 fq_ready
);

    localparam int BW    = FETCH_WIDTH * CPU_DATA_BITS;
    localparam int PTR_W = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CPU_ADDR_BITS-1:0] PC_STEP =
        CPU_ADDR_BITS'(FETCH_WIDTH * 4);
    localparam logic [CPU_ADDR_BITS-1:0] ALIGN_MASK =
        ~CPU_ADDR_BITS'(3);
    localparam logic [CNT_W:0] DEPTH_OCC = (CNT_W + 1)'(FQ_DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FQ_DEPTH);

    logic [CPU_ADDR_BITS-1:0] r_pc;
    logic [CPU_ADDR_BITS-1:0] r_req_pc;
    logic                     r_pend;
    logic [PTR_W-1:0]         r_head;
    logic [PTR_W-1:0]         r_tail;
    logic [CNT_W-1:0]         r_count;
    logic [CPU_ADDR_BITS-1:0] r_fq_pc    [FQ_DEPTH];
    logic [BW-1:0]            r_fq_instr [FQ_DEPTH];

    logic                     w_issue;
    logic                     w_enq;
    logic                     w_deq;
    logic [CNT_W:0]           w_occ;
    logic [CPU_ADDR_BITS-1:0] w_redir_pc;

    // Outstanding request reserves its slot, so an accepted
    // response never finds the queue full.
    assign w_occ      = {1'b0, r_count} + (CNT_W + 1)'(r_pend);
    assign w_issue    = !rst && !redirect_val && (w_occ < DEPTH_OCC);
    assign w_enq      = icache_dout_val && r_pend && !redirect_val;
    assign w_deq      = (r_count != '0) && fq_ready && !redirect_val;
    assign w_redir_pc = redirect_pc & ALIGN_MASK;

    assign icache_addr  = r_pc;
    assign icache_re    = w_issue;
    assign icache_stall = 1'b0;

    assign fq_valid = (r_count != '0);
    assign fq_pc    = r_fq_pc[r_head];
    assign fq_instr = r_fq_instr[r_head];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc     <= RESET_PC;
            r_req_pc <= RESET_PC;
            r_pend   <= 1'b0;
        end else if (redirect_val) begin
            r_pc   <= w_redir_pc;
            r_pend <= 1'b0;
        end else begin
            r_pend <= w_issue;
            if (w_issue) begin
                r_pc     <= r_pc + PC_STEP;
                r_req_pc <= r_pc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || redirect_val) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_enq) begin
                r_tail <= r_tail + PTR_W'(1);
            end
            if (w_deq) begin
                r_head <= r_head + PTR_W'(1);
            end
            unique case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FQ_DEPTH; i++) begin
                r_fq_pc[i]    <= '0;
                r_fq_instr[i] <= '0;
            end
        end else if (w_enq) begin
            r_fq_pc[r_tail]    <= r_req_pc;
            r_fq_instr[r_tail] <= icache_dout;
        end
    end

    a_no_enq_full: assert property (@(posedge clk) disable iff (rst)
        !(w_enq && (r_count == DEPTH_CNT)));

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: 1-cycle memory model, bundle scoreboard and
// directed scenarios for streaming, full queue, redirects and reset.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic [31:0] icache_addr;
    logic        icache_re;
    logic [63:0] icache_dout;
    logic        icache_dout_val;
    logic        icache_stall;
    logic        redirect_val;
    logic [31:0] redirect_pc;
    logic        fq_valid;
    logic [31:0] fq_pc;
    logic [63:0] fq_instr;
    logic        fq_ready;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] sb_q[$];
    logic        infl_v;
    logic [31:0] infl_pc;
    logic [31:0] exp_pc;

    fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .icache_addr    (icache_addr),
        .icache_re      (icache_re),
        .icache_dout    (icache_dout),
        .icache_dout_val(icache_dout_val),
        .icache_stall   (icache_stall),
        .redirect_val   (redirect_val),
        .redirect_pc    (redirect_pc),
        .fq_valid       (fq_valid),
        .fq_pc          (fq_pc),
        .fq_instr       (fq_instr),
        .fq_ready       (fq_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [31:0] a);
        return 32'h1000_0000 + (a >> 2);
    endfunction

    function automatic logic [63:0] bundle(input logic [31:0] a);
        return {word(a + 32'd4), word(a)};
    endfunction

    always @(posedge clk) begin
        icache_dout_val <= icache_re;
        icache_dout     <= bundle(icache_addr);
    end

    // Scoreboard: a request seen in cycle k becomes a queued bundle
    // from cycle k+2; redirect or reset discards everything.
    always @(negedge clk) begin
        if (rst || redirect_val) begin
            sb_q.delete();
            infl_v = 1'b0;
        end else begin
            n_checks++;
            if (fq_valid !== (sb_q.size() != 0)) begin
                n_fail++;
                $display("FAIL sb_valid got=%b want=%b t=%0t",
                         fq_valid, (sb_q.size() != 0), $time);
            end
            if (fq_valid === 1'b1 && fq_ready === 1'b1 &&
                sb_q.size() != 0) begin
                exp_pc = sb_q.pop_front();
                n_checks++;
                if (fq_pc !== exp_pc) begin
                    n_fail++;
                    $display("FAIL sb_pc got=%h want=%h t=%0t",
                             fq_pc, exp_pc, $time);
                end
                n_checks++;
                if (fq_instr !== bundle(exp_pc)) begin
                    n_fail++;
                    $display("FAIL sb_instr got=%h want=%h t=%0t",
                             fq_instr, bundle(exp_pc), $time);
                end
            end
            if (infl_v) sb_q.push_back(infl_pc);
            infl_v  = icache_re;
            infl_pc = icache_addr;
        end
    end

    task automatic do_reset(input logic rdy);
        @(posedge clk);
        #1;
        rst          = 1'b1;
        redirect_val = 1'b0;
        redirect_pc  = 32'h0;
        fq_ready     = rdy;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_reset();
        do_reset(1'b1);
        @(negedge clk);
        n_checks++;
        if (icache_re !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_re got=%b want=0", icache_re);
        end
        n_checks++;
        if (icache_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL rst_addr got=%h want=0", icache_addr);
        end
        n_checks++;
        if (fq_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_fq_valid got=%b want=0", fq_valid);
        end
        n_checks++;
        if (icache_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_stall got=%b want=0", icache_stall);
        end
    endtask

    task automatic test_stream();
        do_reset(1'b1);
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            #1;
            if (c == 0) rst = 1'b0;
            @(negedge clk);
            n_checks++;
            if (icache_re !== 1'b1 || icache_addr !== 32'(8 * c)) begin
                n_fail++;
                $display("FAIL stream_req c=%0d got=%b/%h want=1/%h",
                         c, icache_re, icache_addr, 32'(8 * c));
            end
            if (c < 2) begin
                n_checks++;
                if (fq_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL stream_early c=%0d got=%b want=0",
                             c, fq_valid);
                end
            end else begin
                n_checks++;
                if (fq_valid !== 1'b1 || fq_pc !== 32'(8 * (c - 2))) begin
                    n_fail++;
                    $display("FAIL stream_pc c=%0d got=%b/%h want=1/%h",
                             c, fq_valid, fq_pc, 32'(8 * (c - 2)));
                end
            end
            if (c == 2) begin
                n_checks++;
                if (fq_instr !== 64'h1000_0001_1000_0000) begin
                    n_fail++;
                    $display("FAIL stream_instr got=%h want=%h",
                             fq_instr, 64'h1000_0001_1000_0000);
                end
            end
        end
    endtask

    task automatic test_full();
        do_reset(1'b0);
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (c == 0) rst = 1'b0;
            if (c == 10) fq_ready = 1'b1;
            @(negedge clk);
            if (c >= 6 && c <= 9) begin
                n_checks++;
                if (icache_re !== 1'b0 || fq_valid !== 1'b1 ||
                    fq_pc !== 32'h0) begin
                    n_fail++;
                    $display("FAIL full_hold c=%0d re=%b v=%b pc=%h want 0/1/0",
                             c, icache_re, fq_valid, fq_pc);
                end
            end
            if (c >= 10 && c <= 15) begin
                n_checks++;
                if (fq_valid !== 1'b1 || fq_pc !== 32'(8 * (c - 10))) begin
                    n_fail++;
                    $display("FAIL full_drain c=%0d got=%b/%h want=1/%h",
                             c, fq_valid, fq_pc, 32'(8 * (c - 10)));
                end
            end
            if (c == 11) begin
                n_checks++;
                if (icache_re !== 1'b1 || icache_addr !== 32'h20) begin
                    n_fail++;
                    $display("FAIL full_resume got=%b/%h want=1/%h",
                             icache_re, icache_addr, 32'h20);
                end
            end
        end
    endtask

    task automatic test_redirect();
        do_reset(1'b1);
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            #1;
            if (c == 0) rst = 1'b0;
            if (c == 4) fq_ready = 1'b0;
            if (c == 5) begin
                redirect_val = 1'b1;
                redirect_pc  = 32'h106;
            end
            if (c == 6) begin
                redirect_val = 1'b0;
                fq_ready     = 1'b1;
            end
            @(negedge clk);
            if (c == 5) begin
                n_checks++;
                if (icache_re !== 1'b0) begin
                    n_fail++;
                    $display("FAIL redir_re got=%b want=0", icache_re);
                end
            end
            if (c == 6) begin
                n_checks++;
                if (fq_valid !== 1'b0 || icache_re !== 1'b1 ||
                    icache_addr !== 32'h104) begin
                    n_fail++;
                    $display("FAIL redir_next v=%b re=%b addr=%h want 0/1/104",
                             fq_valid, icache_re, icache_addr);
                end
            end
            if (c == 7) begin
                n_checks++;
                if (icache_addr !== 32'h10c || fq_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL redir_seq addr=%h v=%b want 10c/0",
                             icache_addr, fq_valid);
                end
            end
            if (c == 8) begin
                n_checks++;
                if (fq_valid !== 1'b1 || fq_pc !== 32'h104 ||
                    fq_instr !== 64'h1000_0042_1000_0041) begin
                    n_fail++;
                    $display("FAIL redir_head v=%b pc=%h ins=%h want 1/104/%h",
                             fq_valid, fq_pc, fq_instr,
                             64'h1000_0042_1000_0041);
                end
            end
        end
    endtask

    task automatic test_redirect_accept();
        do_reset(1'b1);
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            if (c == 0) rst = 1'b0;
            if (c == 3) begin
                redirect_val = 1'b1;
                redirect_pc  = 32'h400;
            end
            if (c == 4) redirect_val = 1'b0;
            @(negedge clk);
            if (c == 3) begin
                n_checks++;
                if (fq_valid !== 1'b1 || icache_dout_val !== 1'b1 ||
                    icache_re !== 1'b0) begin
                    n_fail++;
                    $display("FAIL racc_pre v=%b dv=%b re=%b want 1/1/0",
                             fq_valid, icache_dout_val, icache_re);
                end
            end
            if (c == 4 || c == 5) begin
                n_checks++;
                if (fq_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL racc_flush c=%0d got=%b want=0",
                             c, fq_valid);
                end
            end
            if (c == 4) begin
                n_checks++;
                if (icache_addr !== 32'h400 || icache_re !== 1'b1) begin
                    n_fail++;
                    $display("FAIL racc_addr got=%b/%h want=1/400",
                             icache_re, icache_addr);
                end
            end
            if (c == 6) begin
                n_checks++;
                if (fq_valid !== 1'b1 || fq_pc !== 32'h400) begin
                    n_fail++;
                    $display("FAIL racc_head got=%b/%h want=1/400",
                             fq_valid, fq_pc);
                end
            end
        end
    endtask

    task automatic test_rst_mid();
        do_reset(1'b0);
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            if (c == 0) rst = 1'b0;
            if (c == 4) rst = 1'b1;
            if (c == 5) begin
                rst      = 1'b0;
                fq_ready = 1'b1;
            end
            @(negedge clk);
            if (c == 3) begin
                n_checks++;
                if (fq_valid !== 1'b1) begin
                    n_fail++;
                    $display("FAIL rmid_pre got=%b want=1", fq_valid);
                end
            end
            if (c == 4) begin
                n_checks++;
                if (icache_re !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rmid_re got=%b want=0", icache_re);
                end
            end
            if (c == 5) begin
                n_checks++;
                if (icache_re !== 1'b1 || icache_addr !== 32'h0 ||
                    fq_valid !== 1'b0 || icache_stall !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rmid_clr re=%b a=%h v=%b st=%b want 1/0/0/0",
                             icache_re, icache_addr, fq_valid, icache_stall);
                end
            end
            if (c == 6) begin
                n_checks++;
                if (fq_valid !== 1'b0 || icache_addr !== 32'h8) begin
                    n_fail++;
                    $display("FAIL rmid_gap v=%b a=%h want 0/8",
                             fq_valid, icache_addr);
                end
            end
            if (c == 7) begin
                n_checks++;
                if (fq_valid !== 1'b1 || fq_pc !== 32'h0 ||
                    fq_instr !== bundle(32'h0)) begin
                    n_fail++;
                    $display("FAIL rmid_head v=%b pc=%h ins=%h want 1/0/%h",
                             fq_valid, fq_pc, fq_instr, bundle(32'h0));
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset(1'b1);
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            if (c == 0) rst = 1'b0;
            if (c == 3) begin
                redirect_val = 1'b1;
                redirect_pc  = 32'h200;
            end
            if (c == 4) redirect_pc = 32'h300;
            if (c == 5) redirect_val = 1'b0;
            @(negedge clk);
            if (c == 4) begin
                n_checks++;
                if (icache_re !== 1'b0 || fq_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL b2b_mid re=%b v=%b want 0/0",
                             icache_re, fq_valid);
                end
            end
            if (c == 5) begin
                n_checks++;
                if (icache_re !== 1'b1 || icache_addr !== 32'h300) begin
                    n_fail++;
                    $display("FAIL b2b_addr got=%b/%h want=1/300",
                             icache_re, icache_addr);
                end
            end
            if (c == 7) begin
                n_checks++;
                if (fq_valid !== 1'b1 || fq_pc !== 32'h300) begin
                    n_fail++;
                    $display("FAIL b2b_head got=%b/%h want=1/300",
                             fq_valid, fq_pc);
                end
            end
        end
    endtask

    task automatic test_wrap();
        do_reset(1'b1);
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            if (c == 0) rst = 1'b0;
            if (c == 3) begin
                redirect_val = 1'b1;
                redirect_pc  = 32'hffff_fffb;
            end
            if (c == 4) redirect_val = 1'b0;
            @(negedge clk);
            if (c == 4) begin
                n_checks++;
                if (icache_addr !== 32'hffff_fff8) begin
                    n_fail++;
                    $display("FAIL wrap_align got=%h want=fffffff8",
                             icache_addr);
                end
            end
            if (c == 5) begin
                n_checks++;
                if (icache_addr !== 32'h0) begin
                    n_fail++;
                    $display("FAIL wrap_pc got=%h want=0", icache_addr);
                end
            end
            if (c == 6) begin
                n_checks++;
                if (fq_pc !== 32'hffff_fff8 ||
                    fq_instr !== 64'h4fff_ffff_4fff_fffe) begin
                    n_fail++;
                    $display("FAIL wrap_head pc=%h ins=%h want fffffff8/%h",
                             fq_pc, fq_instr, 64'h4fff_ffff_4fff_fffe);
                end
            end
            if (c == 7) begin
                n_checks++;
                if (fq_valid !== 1'b1 || fq_pc !== 32'h0) begin
                    n_fail++;
                    $display("FAIL wrap_next got=%b/%h want=1/0",
                             fq_valid, fq_pc);
                end
            end
        end
    endtask

    initial begin
        rst          = 1'b1;
        redirect_val = 1'b0;
        redirect_pc  = 32'h0;
        fq_ready     = 1'b0;
        infl_v       = 1'b0;
        infl_pc      = 32'h0;
        test_reset();
        test_stream();
        test_full();
        test_redirect();
        test_redirect_accept();
        test_rst_mid();
        test_back_to_back();
        test_wrap();
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout t=%0t", $time);
        $fatal(1, "timeout");
    end

endmodule
